// File: rtl/tl_traffic_model_if.sv
// tl_traffic_model_if: light codes and arrivals into the traffic model; sensors, counts and status out
interface tl_traffic_model_if #(
    parameter int QW = 4
);
    logic [1:0] La;
    logic [1:0] Lb;
    logic arr_a;
    logic arr_b;
    logic Ta;
    logic Tb;
    logic [QW-1:0] cnt_a;
    logic [QW-1:0] cnt_b;
    logic dep_a;
    logic dep_b;
    logic ovf;
    logic err;
    modport master (
        output La, Lb, arr_a, arr_b,
        input Ta, Tb, cnt_a, cnt_b, dep_a, dep_b, ovf, err
    );
    modport slave (
        input La, Lb, arr_a, arr_b,
        output Ta, Tb, cnt_a, cnt_b, dep_a, dep_b, ovf, err
    );
endinterface

// File: rtl/tl_traffic_model.sv
// tl_traffic_model: per-street vehicle queues, Ta/Tb sensors and light sequence monitor; TLM_YELLOW_DEPART_EN lets yellow drain queues too
module tl_traffic_model #(
    parameter int QW = 4,
    parameter int DEP_CYC = 3
) (
    input logic clk,
    input logic reset_n,
    tl_traffic_model_if.slave bus
);
    localparam int TW = DEP_CYC > 1 ? $clog2(DEP_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(DEP_CYC - 1);
    localparam logic [QW-1:0] QMAX = '1;
    typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10} st_t;
    logic chk;
    logic ovf_q;
    logic err_q;
    logic conflict;
    for (genvar s = 0; s < 2; s++) begin : g_st
        logic [1:0] lc;
        logic arr;
        logic go;
        logic fire;
        logic full;
        logic bad;
        logic dep;
        logic [TW-1:0] tmr;
        logic [QW-1:0] q;
        st_t st;
        st_t nst;
        assign lc = s == 0 ? bus.La : bus.Lb;
        assign arr = s == 0 ? bus.arr_a : bus.arr_b;
`ifdef TLM_YELLOW_DEPART_EN
        assign go = lc == 2'b00 || lc == 2'b01;
`else
        assign go = lc == 2'b00;
`endif
        assign fire = go && q != '0 && tmr == TMAX;
        assign full = arr && !fire && q == QMAX;
        // departure timer: runs while the street can drain, restarts after each departure
        always_ff @(posedge clk)
            if (!reset_n) tmr <= '0;
            else tmr <= (!go || q == '0 || fire) ? '0 : tmr + 1'b1;
        // queue count with saturating arrivals and a registered departure pulse
        always_ff @(posedge clk)
            if (!reset_n) begin
                q <= '0;
                dep <= 1'b0;
            end else begin
                dep <= fire;
                if (arr && !fire && q != QMAX) q <= q + 1'b1;
                else if (fire && !arr) q <= q - 1'b1;
            end
        // monitor state register: last sampled light
        always_ff @(posedge clk)
            if (!reset_n) st <= RED;
            else st <= nst;
        // monitor next state: always follow the observed code, illegal code treated as red
        always_comb nst = lc == 2'b11 ? RED : st_t'(lc);
        // monitor output: flag illegal code or any move outside hold/G->Y/Y->R/R->G
        always_comb bad = lc == 2'b11 || !(lc == st || (st == GREEN && lc == YELLOW) || (st == YELLOW && lc == RED) || (st == RED && lc == GREEN));
    end
    assign conflict = chk && bus.La != 2'b10 && bus.Lb != 2'b10;
    // sticky status flags; conflict checking starts one cycle after reset release
    always_ff @(posedge clk)
        if (!reset_n) begin
            chk <= 1'b0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            chk <= 1'b1;
            ovf_q <= ovf_q | g_st[0].full | g_st[1].full;
            err_q <= err_q | g_st[0].bad | g_st[1].bad | conflict;
        end
    assign bus.cnt_a = g_st[0].q;
    assign bus.cnt_b = g_st[1].q;
    assign bus.Ta = g_st[0].q != '0;
    assign bus.Tb = g_st[1].q != '0;
    assign bus.dep_a = g_st[0].dep;
    assign bus.dep_b = g_st[1].dep;
    assign bus.ovf = ovf_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_tl_traffic_model.sv
// tb_tl_traffic_model: directed scenarios for queues, departures, saturation, monitor and reset
module tb_tl_traffic_model;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    tl_traffic_model_if #(.QW(4)) bus ();
    tl_traffic_model #(.QW(4), .DEP_CYC(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    // advance n rising edges and settle just after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        bus.La = 2'b10;
        bus.Lb = 2'b10;
        bus.arr_a = 1'b0;
        bus.arr_b = 1'b0;
        step(1);
        reset_n = 1'b1;
    endtask
    task automatic test_reset();
        do_reset();
        checks++; if (bus.cnt_a !== 4'd0) begin failures++; $display("FAIL rst_cnt_a got=%0d exp=0", bus.cnt_a); end
        checks++; if (bus.cnt_b !== 4'd0) begin failures++; $display("FAIL rst_cnt_b got=%0d exp=0", bus.cnt_b); end
        checks++; if ({bus.Ta, bus.Tb} !== 2'b00) begin failures++; $display("FAIL rst_t got=%b exp=00", {bus.Ta, bus.Tb}); end
        checks++; if ({bus.dep_a, bus.dep_b} !== 2'b00) begin failures++; $display("FAIL rst_dep got=%b exp=00", {bus.dep_a, bus.dep_b}); end
        checks++; if ({bus.ovf, bus.err} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {bus.ovf, bus.err}); end
    endtask
    task automatic test_arrival();
        do_reset();
        bus.Lb = 2'b00;
        bus.arr_a = 1'b1;
        step(1);
        bus.arr_a = 1'b0;
        checks++; if (bus.Ta !== 1'b1) begin failures++; $display("FAIL arr_ta got=%b exp=1", bus.Ta); end
        checks++; if (bus.cnt_a !== 4'd1) begin failures++; $display("FAIL arr_cnt1 got=%0d exp=1", bus.cnt_a); end
        step(1);
        bus.arr_a = 1'b1;
        step(1);
        bus.arr_a = 1'b0;
        checks++; if (bus.cnt_a !== 4'd2) begin failures++; $display("FAIL arr_cnt2 got=%0d exp=2", bus.cnt_a); end
        step(2);
        checks++; if (bus.cnt_a !== 4'd2) begin failures++; $display("FAIL arr_hold got=%0d exp=2", bus.cnt_a); end
        checks++; if (bus.dep_a !== 1'b0) begin failures++; $display("FAIL arr_dep got=%b exp=0", bus.dep_a); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL arr_err got=%b exp=0", bus.err); end
    endtask
    task automatic test_departure();
        do_reset();
        bus.arr_b = 1'b1;
        step(2);
        bus.arr_b = 1'b0;
        step(1);
        checks++; if (bus.cnt_b !== 4'd2) begin failures++; $display("FAIL dep_pre got=%0d exp=2", bus.cnt_b); end
        bus.Lb = 2'b00;
        step(2);
        checks++; if ({bus.dep_b, bus.cnt_b} !== {1'b0, 4'd2}) begin failures++; $display("FAIL dep_c2 got=%b/%0d exp=0/2", bus.dep_b, bus.cnt_b); end
        step(1);
        checks++; if ({bus.dep_b, bus.cnt_b} !== {1'b1, 4'd1}) begin failures++; $display("FAIL dep_c3 got=%b/%0d exp=1/1", bus.dep_b, bus.cnt_b); end
        checks++; if (bus.Tb !== 1'b1) begin failures++; $display("FAIL dep_tb1 got=%b exp=1", bus.Tb); end
        step(1);
        checks++; if (bus.dep_b !== 1'b0) begin failures++; $display("FAIL dep_c4 got=%b exp=0", bus.dep_b); end
        step(1);
        checks++; if (bus.dep_b !== 1'b0) begin failures++; $display("FAIL dep_c5 got=%b exp=0", bus.dep_b); end
        step(1);
        checks++; if ({bus.dep_b, bus.cnt_b} !== {1'b1, 4'd0}) begin failures++; $display("FAIL dep_c6 got=%b/%0d exp=1/0", bus.dep_b, bus.cnt_b); end
        checks++; if (bus.Tb !== 1'b0) begin failures++; $display("FAIL dep_tb0 got=%b exp=0", bus.Tb); end
        step(4);
        checks++; if ({bus.dep_b, bus.cnt_b} !== {1'b0, 4'd0}) begin failures++; $display("FAIL dep_under got=%b/%0d exp=0/0", bus.dep_b, bus.cnt_b); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL dep_err got=%b exp=0", bus.err); end
    endtask
    task automatic test_coincident();
        do_reset();
        bus.arr_b = 1'b1;
        step(1);
        bus.arr_b = 1'b0;
        bus.Lb = 2'b00;
        step(2);
        bus.arr_b = 1'b1;
        step(1);
        bus.arr_b = 1'b0;
        checks++; if ({bus.dep_b, bus.cnt_b} !== {1'b1, 4'd1}) begin failures++; $display("FAIL coin got=%b/%0d exp=1/1", bus.dep_b, bus.cnt_b); end
        step(3);
        checks++; if ({bus.dep_b, bus.cnt_b} !== {1'b1, 4'd0}) begin failures++; $display("FAIL coin_next got=%b/%0d exp=1/0", bus.dep_b, bus.cnt_b); end
    endtask
    task automatic test_saturation();
        do_reset();
        bus.arr_a = 1'b1;
        step(15);
        checks++; if ({bus.ovf, bus.cnt_a} !== {1'b0, 4'd15}) begin failures++; $display("FAIL sat15 got=%b/%0d exp=0/15", bus.ovf, bus.cnt_a); end
        step(1);
        checks++; if ({bus.ovf, bus.cnt_a} !== {1'b1, 4'd15}) begin failures++; $display("FAIL sat16 got=%b/%0d exp=1/15", bus.ovf, bus.cnt_a); end
        step(1);
        bus.arr_a = 1'b0;
        checks++; if ({bus.ovf, bus.cnt_a} !== {1'b1, 4'd15}) begin failures++; $display("FAIL sat17 got=%b/%0d exp=1/15", bus.ovf, bus.cnt_a); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL sat_err got=%b exp=0", bus.err); end
    endtask
    task automatic test_monitor();
        do_reset();
        step(1);
        bus.La = 2'b00;
        step(1);
        bus.La = 2'b01;
        step(1);
        bus.La = 2'b10;
        step(1);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mon_legal got=%b exp=0", bus.err); end
        bus.La = 2'b00;
        step(1);
        bus.La = 2'b10;
        step(1);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL mon_skip got=%b exp=1", bus.err); end
        step(3);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL mon_sticky got=%b exp=1", bus.err); end
        do_reset();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mon_rst got=%b exp=0", bus.err); end
        step(1);
        bus.Lb = 2'b00;
        step(1);
        bus.Lb = 2'b01;
        step(1);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mon_lb got=%b exp=0", bus.err); end
        bus.La = 2'b00;
        step(1);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL mon_conflict got=%b exp=1", bus.err); end
        do_reset();
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mon_rst2 got=%b exp=0", bus.err); end
        bus.La = 2'b00;
        bus.Lb = 2'b00;
        step(1);
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mon_first got=%b exp=0", bus.err); end
        step(1);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL mon_both got=%b exp=1", bus.err); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        bus.arr_a = 1'b1;
        step(5);
        bus.arr_a = 1'b0;
        checks++; if (bus.cnt_a !== 4'd5) begin failures++; $display("FAIL mid_pre got=%0d exp=5", bus.cnt_a); end
        bus.La = 2'b00;
        step(1);
        reset_n = 1'b0;
        step(1);
        checks++; if ({bus.Ta, bus.dep_a, bus.cnt_a} !== {1'b0, 1'b0, 4'd0}) begin failures++; $display("FAIL mid_rst got=%b/%b/%0d exp=0/0/0", bus.Ta, bus.dep_a, bus.cnt_a); end
        reset_n = 1'b1;
        bus.La = 2'b10;
        step(3);
        checks++; if ({bus.dep_a, bus.cnt_a} !== {1'b0, 4'd0}) begin failures++; $display("FAIL mid_after got=%b/%0d exp=0/0", bus.dep_a, bus.cnt_a); end
    endtask
    initial begin
        test_reset();
        test_arrival();
        test_departure();
        test_coincident();
        test_saturation();
        test_monitor();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
